// File: rtl/serial_datapath.sv
// Bit-serial ALU datapath: operand shift registers, 1-bit ALU, carry flop,
// result shift register and wrapping bit counter, driven by external strobes.
module serial_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] imm,
  input  logic             sub,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             shift_a,
  input  logic             shift_b,
  input  logic             shift_out,
  input  logic             load_out,
  input  logic             carry_en,
  input  logic             clr_counter,
  input  logic             en_counter,
  input  logic [1:0]       alu_op,
  output logic             bit_done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             result_valid
);

  localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] r_reg;
  logic             c_reg;
  logic [CW-1:0]    cnt;

  logic bit_a;
  logic bit_b;
  logic alu_bit;
  logic carry_nxt;
  logic cnt_last;

  always_comb begin
    bit_a     = a_reg[0];
    bit_b     = b_reg[0] ^ sub;
    carry_nxt = (bit_a & bit_b) | (c_reg & (bit_a ^ bit_b));
    alu_bit   = 1'b0;
    case (alu_op)
      2'b00:   alu_bit = bit_a ^ bit_b ^ c_reg;
      2'b01:   alu_bit = bit_a ^ bit_b;
      2'b10:   alu_bit = bit_a & bit_b;
      default: alu_bit = bit_a | bit_b;
    endcase
    cnt_last = (cnt == CNT_LAST);
    bit_done = en_counter & cnt_last & ~clr_counter & ~rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      r_reg        <= '0;
      c_reg        <= 1'b0;
      cnt          <= '0;
      result       <= '0;
      cout         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      if (load_a)
        a_reg <= opa;
      else if (shift_a)
        a_reg <= {1'b0, a_reg[WIDTH-1:1]};

      // R-type load overrides the immediate that load_a would place in B
      if (load_b)
        b_reg <= opb;
      else if (load_a)
        b_reg <= imm;
      else if (shift_b)
        b_reg <= {1'b0, b_reg[WIDTH-1:1]};

      if (shift_out)
        r_reg <= {alu_bit, r_reg[WIDTH-1:1]};

      if (clr_counter)
        c_reg <= sub;
      else if (carry_en)
        c_reg <= carry_nxt;

      if (clr_counter)
        cnt <= '0;
      else if (en_counter)
        cnt <= cnt_last ? '0 : cnt + 1'b1;

      if (load_out) begin
        result <= r_reg;
        cout   <= c_reg;
      end
      result_valid <= load_out;
    end
  end

endmodule

// File: tb/tb_serial_datapath.sv
// Directed self-checking bench for serial_datapath (WIDTH=8).
module tb_serial_datapath;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] opa, opb, imm;
  logic         sub;
  logic         load_a, load_b, shift_a, shift_b, shift_out, load_out;
  logic         carry_en, clr_counter, en_counter;
  logic [1:0]   alu_op;
  logic         bit_done;
  logic [W-1:0] result;
  logic         cout;
  logic         result_valid;

  int checks = 0;
  int errors = 0;

  serial_datapath #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .opa(opa), .opb(opb), .imm(imm), .sub(sub),
    .load_a(load_a), .load_b(load_b), .shift_a(shift_a), .shift_b(shift_b),
    .shift_out(shift_out), .load_out(load_out), .carry_en(carry_en),
    .clr_counter(clr_counter), .en_counter(en_counter), .alu_op(alu_op),
    .bit_done(bit_done), .result(result), .cout(cout),
    .result_valid(result_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] im;
    logic       s;
    logic       use_imm;
    logic [1:0] op;
    logic [7:0] exp_res;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_a = 0; load_b = 0; shift_a = 0; shift_b = 0; shift_out = 0;
    load_out = 0; carry_en = 0; clr_counter = 0; en_counter = 0;
  endtask

  // Load, W serial cycles (bit_done checked each cycle), then latch the result.
  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] im, input logic s, input logic use_imm,
                        input logic [1:0] op);
    idle();
    opa = a; opb = b; imm = im; sub = s; alu_op = op;
    load_a = 1; load_b = ~use_imm; clr_counter = 1;
    tick();
    idle();
    for (int unsigned i = 0; i < W; i++) begin
      shift_a = 1; shift_b = 1; shift_out = 1; en_counter = 1;
      carry_en = (op == 2'b00);
      #1;
      chk({name, " bit_done"}, bit_done, (i == W - 1));
      tick();
    end
    idle();
    load_out = 1;
    tick();
    idle();
  endtask

  initial begin
    vecs[0] = '{"add_5a_c3", 8'h5A, 8'hC3, 8'hAA, 1'b0, 1'b0, 2'b00, 8'h1D, 1'b1};
    vecs[1] = '{"sub_10_01", 8'h10, 8'h01, 8'hAA, 1'b1, 1'b0, 2'b00, 8'h0F, 1'b1};
    vecs[2] = '{"sub_01_02", 8'h01, 8'h02, 8'hAA, 1'b1, 1'b0, 2'b00, 8'hFF, 1'b0};
    vecs[3] = '{"xor_imm",   8'hF0, 8'h55, 8'h3C, 1'b0, 1'b1, 2'b01, 8'hCC, 1'b0};
    vecs[4] = '{"and_imm",   8'hF0, 8'h55, 8'h3C, 1'b0, 1'b1, 2'b10, 8'h30, 1'b0};
    vecs[5] = '{"or_imm",    8'hF0, 8'h55, 8'h3C, 1'b0, 1'b1, 2'b11, 8'hFC, 1'b0};
    vecs[6] = '{"add_ff_01", 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0, 2'b00, 8'h00, 1'b1};

    idle();
    opa = '0; opb = '0; imm = '0; sub = 0; alu_op = 2'b00;
    rst = 1;
    tick(); tick();
    chk("reset result", result, 0);
    chk("reset cout", cout, 0);
    chk("reset valid", result_valid, 0);
    rst = 0;

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].im, vecs[i].s,
             vecs[i].use_imm, vecs[i].op);
      chk({vecs[i].name, " result"}, result, vecs[i].exp_res);
      chk({vecs[i].name, " cout"}, cout, vecs[i].exp_cout);
      chk({vecs[i].name, " valid"}, result_valid, 1);
      tick();
      chk({vecs[i].name, " valid_drop"}, result_valid, 0);
    end

    // Idle cycles hold everything; relatching gives the same value.
    tick(); tick();
    load_out = 1; tick(); idle();
    chk("hold result", result, 8'h00);
    chk("hold cout", cout, 1);

    // Counter wrap across 16 enables after a single clear.
    clr_counter = 1; tick(); idle();
    for (int unsigned i = 1; i <= 16; i++) begin
      en_counter = 1; #1;
      chk("wrap bit_done", bit_done, (i == 8 || i == 16));
      tick();
    end
    idle();
    clr_counter = 1; tick(); idle();
    for (int unsigned i = 1; i <= 8; i++) begin
      en_counter = 1; clr_counter = (i == 8); #1;
      chk("clr_on_last bit_done", bit_done, 0);
      tick();
    end
    idle();
    for (int unsigned i = 1; i <= 8; i++) begin
      en_counter = 1; #1;
      chk("after_clr bit_done", bit_done, (i == 8));
      tick();
    end
    idle();

    // bit_done suppressed under reset even at the last count.
    clr_counter = 1; tick(); idle();
    en_counter = 1;
    for (int unsigned i = 0; i < 7; i++) tick();
    rst = 1; #1;
    chk("rst bit_done", bit_done, 0);
    tick(); rst = 0; idle();

    // Build nonzero outputs, then reset in the middle of an operation.
    run_op("pre_rst", 8'h5A, 8'hC3, 8'h00, 1'b0, 1'b0, 2'b00);
    chk("pre_rst valid", result_valid, 1);
    opa = 8'h01; opb = 8'h01; sub = 0; alu_op = 2'b00;
    load_a = 1; load_b = 1; clr_counter = 1; tick(); idle();
    for (int unsigned i = 0; i < 3; i++) begin
      shift_a = 1; shift_b = 1; shift_out = 1; carry_en = 1; en_counter = 1;
      tick();
    end
    load_out = 1; rst = 1;
    tick();
    rst = 0; idle();
    chk("midrst result", result, 0);
    chk("midrst cout", cout, 0);
    chk("midrst valid", result_valid, 0);
    load_out = 1; tick(); idle();
    chk("midrst R cleared", result, 0);
    run_op("add_01_01", 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 2'b00);
    chk("add_01_01 result", result, 8'h02);
    chk("add_01_01 cout", cout, 0);

    // load_a wins over shift_a on the same cycle.
    opa = 8'h81; opb = 8'h00; imm = 8'hFF; sub = 0; alu_op = 2'b01;
    load_a = 1; load_b = 1; shift_a = 1; shift_b = 1; clr_counter = 1;
    tick(); idle();
    for (int unsigned i = 0; i < W; i++) begin
      shift_a = 1; shift_b = 1; shift_out = 1; en_counter = 1;
      tick();
    end
    idle();
    load_out = 1; tick(); idle();
    chk("load_over_shift result", result, 8'h81);

    // load_out held three cycles: valid high three cycles, then low.
    load_out = 1;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      chk("held valid", result_valid, 1);
    end
    idle();
    tick();
    chk("held valid drop", result_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_datapath.md
SERIAL_DATAPATH -- requirements
Module: serial_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand, result and shift-register width in bits (legal values 2..16).
REQ-002 SHALL have clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1: reset, synchronous and active-high.
REQ-004 SHALL have opa  input  WIDTH: parallel value for operand register A.
REQ-005 SHALL have opb  input  WIDTH: parallel value for operand register B (R-type).
REQ-006 SHALL have imm  input  WIDTH: immediate value for B (I-type).
REQ-007 SHALL have sub  input  1: subtract mode; B bits inverted, carry seeded with 1.
REQ-008 SHALL have load_a, load_b, shift_a, shift_b, shift_out, load_out, carry_en, clr_counter, en_counter  input  1 each: command strobes from the control FSM.
REQ-009 SHALL have alu_op  input  2: 00 ADD/SUB, 01 XOR, 10 AND, 11 OR.
REQ-010 SHALL have bit_done  output  1: last-bit indication to the control FSM.
REQ-011 SHALL have result  output  WIDTH: latched result.
REQ-012 SHALL have cout  output  1: latched final carry.
REQ-013 SHALL have result_valid  output  1: one-cycle pulse after each result latch.

Function
REQ-014 SHALL hold registers A, B, R (WIDTH each), carry flop C, bit counter CNT (clog2(WIDTH) bits).
REQ-015 load_a SHALL load A<=opa and B<=imm in the same cycle.
REQ-016 load_b SHALL load B<=opb; if load_a and load_b are both asserted, B SHALL take opb.
REQ-017 shift_a SHALL shift A right (A<={0,A[WIDTH-1:1]}); shift_b likewise for B; a load SHALL win over a shift in the same cycle.
REQ-018 Current bit operands: a=A[0], b=B[0] XOR sub, c=C.
REQ-019 alu_bit SHALL be a^b^c for ADD/SUB, a^b for XOR, a&b for AND, a|b for OR (combinational).
REQ-020 shift_out SHALL update R<={alu_bit, R[WIDTH-1:1]}, so after WIDTH shifts R[0] holds the first (LSB) result bit.
REQ-021 carry_en SHALL update C<=(a&b)|(c&(a^b)); with carry_en low, C SHALL hold.
REQ-022 clr_counter SHALL set CNT<=0 and C<=sub; clr_counter SHALL take priority over en_counter and carry_en.
REQ-023 en_counter SHALL increment CNT; at CNT==WIDTH-1, CNT SHALL wrap to 0.
REQ-024 bit_done SHALL be combinational: en_counter AND CNT==WIDTH-1 AND NOT clr_counter.
REQ-025 The FSM's EXECUTE and WRITE_OUT phases SHALL each last exactly WIDTH en_counter cycles, with no clr_counter between them (relies on the wrap).
REQ-026 load_out SHALL latch result<=R and cout<=C, and SHALL assert result_valid for exactly the next cycle.
REQ-027 With load_out held for N cycles, the latch SHALL repeat every cycle and result_valid SHALL stay high for N cycles.
REQ-028 Strobes SHALL be independent: any combination in one cycle SHALL act per the priorities above, with no lockup.
REQ-029 No command asserted SHALL mean all registers hold.

Reset
REQ-030 rst SHALL clear A, B, R, C, CNT, result, cout and result_valid to 0, taking priority over every strobe.
REQ-031 bit_done SHALL be 0 during rst regardless of en_counter.
REQ-032 rst asserted mid-operation SHALL abandon the operation; the next operation after release SHALL need a fresh load_a.

Verification
REQ-033 ADD, WIDTH=8, opa=0x5A, opb=0xC3, 8 cycles of shift_a/b/out+carry_en+en_counter -> result=0x1D, cout=1, bit_done high only on 8th cycle.
REQ-034 SUB (sub=1), opa=0x10, opb=0x01 -> result=0x0F, cout=1; opa=0x01, opb=0x02 -> result=0xFF, cout=0.
REQ-035 I-type XOR: load_a only with opa=0xF0, imm=0x3C, alu_op=01 -> result=0xCC; AND with imm=0x3C -> 0x30; OR -> 0xFC.
REQ-036 Counter wrap: 16 consecutive en_counter cycles after one clr_counter -> bit_done high on cycles 8 and 16 only; clr_counter with en_counter on cycle 8 -> bit_done stays low.
REQ-037 Reset mid-EXECUTE after 3 shifts -> all outputs 0 the next cycle; a full ADD 0x01+0x01 afterwards -> result=0x02.
REQ-038 Priority: load_a+shift_a same cycle -> A=opa; load_a+load_b -> B=opb; load_out -> result_valid exactly one cycle.
